audio_frame_sched: RTL and testbench

- Frame-level sample scheduler in front of the PCM5102 I2S serializer.
- Buffers DMA-sound stereo samples in a FIFO and mixes them with the live mix (AY/beeper/covox), with saturation.
- Presents stable left/right words to the DAC, updated once per I2S frame and timed from the DAC's lrck.
- Flags FIFO underrun and overflow to the CPU-side register block.

---
 rtl/audio_frame_sched_if.sv | 39 +++
 rtl/audio_frame_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_audio_frame_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_sched_if.sv
// audio_frame_sched_if: control, FIFO write and DAC-side bundle
// master = CPU/mixer side, slave = scheduler
interface audio_frame_sched_if #(
  parameter int FIFO_AW = 4
);
  logic               lrck;
  logic [1:0]         mode;
  logic [1:0]         fifo_vol;
  logic [15:0]        live_left;
  logic [15:0]        live_right;
  logic               fifo_wr;
  logic [31:0]        fifo_din;
  logic               flags_clr;
  logic               fifo_full;
  logic [FIFO_AW:0]   fifo_level;
  logic               underrun;
  logic               overflow;
  logic [15:0]        left;
  logic [15:0]        right;
  logic               frame_tick;

  modport master (
    output lrck, mode, fifo_vol,
    output live_left, live_right,
    output fifo_wr, fifo_din, flags_clr,
    input  fifo_full, fifo_level,
    input  underrun, overflow,
    input  left, right, frame_tick
  );

  modport slave (
    input  lrck, mode, fifo_vol,
    input  live_left, live_right,
    input  fifo_wr, fifo_din, flags_clr,
    output fifo_full, fifo_level,
    output underrun, overflow,
    output left, right, frame_tick
  );
endinterface

// File: rtl/audio_frame_sched.sv
// audio_frame_sched: per-frame DAC sample scheduler
// FWFT stereo FIFO mixed with live audio, retimed from DAC lrck
module audio_frame_sched #(
  parameter int          FIFO_AW  = 4,
  parameter logic [15:0] MIDSCALE = 16'h8000
) (
  input logic                clk,
  input logic                reset,
  audio_frame_sched_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_FULL =
    {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    MIX,
    UPDATE
  } state_e;

  // offset-binary <-> two's complement is its own inverse
  function automatic logic [15:0] flip(
    input logic [15:0] x
  );
    return {~x[15], x[14:0]};
  endfunction

  function automatic logic [15:0] mix_ch(
    input logic [1:0]  m,
    input logic [1:0]  v,
    input logic [15:0] live_u,
    input logic [15:0] fifo_u
  );
    logic signed [15:0] sl;
    logic signed [15:0] sf;
    logic        [16:0] sum;
    logic        [15:0] r;
    sl  = $signed(flip(live_u));
    sf  = $signed(flip(fifo_u)) >>> v;
    sum = {sl[15], sl} + {sf[15], sf};
    r   = '0;
    unique case (1'b1)
      m == 2'd0: r = sl;
      m == 2'd1: r = sf;
      m == 2'd2: begin
        if (sum[16] != sum[15])
          r = sum[16] ? 16'h8000 : 16'h7fff;
        else
          r = sum[15:0];
      end
      m == 2'd3: r = '0;
      default:   r = '0;
    endcase
    return r;
  endfunction

  logic lr_s1_q, lr_s2_q, lr_prev_q;
  logic edge_w;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  vol_q, vol_d;
  logic [31:0] head_q, head_d;
  logic [31:0] live_q, live_d;
  logic [31:0] mix_q, mix_d;
  logic [31:0] out_q, out_d;
  logic        tick_q, tick_d;
  logic        under_q, under_d;
  logic        ovf_q, ovf_d;

  logic [31:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic        need_fifo;
  logic        pop;
  logic        under_set;
  logic        wr_acc;
  logic        ovf_set;
  logic [31:0] head_w;

  assign edge_w = lr_s2_q & ~lr_prev_q;

  assign need_fifo = (state_q == FETCH) &&
                     ((mode_q == 2'd1) ||
                      (mode_q == 2'd2));
  assign pop       = need_fifo & ~empty_q;
  assign under_set = need_fifo & empty_q;
  assign wr_acc    = bus.fifo_wr & ~full_q;
  assign ovf_set   = bus.fifo_wr & full_q;
  assign head_w    = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vol_d   = vol_q;
    head_d  = head_q;
    live_d  = live_q;
    mix_d   = mix_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (edge_w) begin
          state_d = FETCH;
          mode_d  = bus.mode;
          vol_d   = bus.fifo_vol;
        end
      end
      FETCH: begin
        state_d = MIX;
        head_d  = pop ? head_w
                      : {MIDSCALE, MIDSCALE};
        live_d  = {bus.live_left,
                   bus.live_right};
      end
      MIX: begin
        state_d = UPDATE;
        mix_d   = {
          mix_ch(mode_q, vol_q,
                 live_q[31:16], head_q[31:16]),
          mix_ch(mode_q, vol_q,
                 live_q[15:0], head_q[15:0])
        };
      end
      UPDATE: begin
        state_d = IDLE;
        out_d   = {flip(mix_q[31:16]),
                   flip(mix_q[15:0])};
        tick_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // clear beats a same-cycle set
  always_comb begin
    under_d = under_q | under_set;
    ovf_d   = ovf_q | ovf_set;
    if (bus.flags_clr) begin
      under_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc)
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !wr_acc)
      count_d = count_q - CNT_ONE;
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem_q[wr_ptr_q] <= bus.fifo_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      lr_prev_q <= 1'b0;
      state_q   <= IDLE;
      mode_q    <= '0;
      vol_q     <= '0;
      head_q    <= {MIDSCALE, MIDSCALE};
      live_q    <= {MIDSCALE, MIDSCALE};
      mix_q     <= '0;
      out_q     <= {MIDSCALE, MIDSCALE};
      tick_q    <= 1'b0;
      under_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      lr_s1_q   <= bus.lrck;
      lr_s2_q   <= lr_s1_q;
      lr_prev_q <= lr_s2_q;
      state_q   <= state_d;
      mode_q    <= mode_d;
      vol_q     <= vol_d;
      head_q    <= head_d;
      live_q    <= live_d;
      mix_q     <= mix_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      under_q   <= under_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign bus.left       = out_q[31:16];
  assign bus.right      = out_q[15:0];
  assign bus.frame_tick = tick_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_level = count_q;
  assign bus.underrun   = under_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_audio_frame_sched.sv
// tb_audio_frame_sched: scenario tasks plus randomized frames
// checked against an arithmetic reference model
module tb_audio_frame_sched;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  audio_frame_sched_if #(.FIFO_AW(AW)) bus();

  audio_frame_sched #(
    .FIFO_AW (AW),
    .MIDSCALE(16'h8000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] q_m[$];
  bit          und_m, ovf_m;
  logic [15:0] e_l, e_r, p_l, p_r;

  int          o_first, o_hi;
  logic [15:0] o_l5, o_r5, o_l6, o_r6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_ch(
    int m, int v, logic [15:0] lv, logic [15:0] fv
  );
    int sl, sf, o;
    sl = int'(lv) - 32768;
    sf = (int'(fv) - 32768) >>> v;
    case (m)
      0: o = sl;
      1: o = sf;
      2: begin
        o = sl + sf;
        if (o > 32767) o = 32767;
        if (o < -32768) o = -32768;
      end
      default: o = 0;
    endcase
    return 16'(o + 32768);
  endfunction

  task automatic push(input logic [31:0] d);
    bus.fifo_wr  = 1'b1;
    bus.fifo_din = d;
    tick();
    bus.fifo_wr  = 1'b0;
    if (q_m.size() < DEPTH) q_m.push_back(d);
    else ovf_m = 1'b1;
  endtask

  task automatic clr_flags();
    bus.flags_clr = 1'b1;
    tick();
    bus.flags_clr = 1'b0;
    und_m = 1'b0;
    ovf_m = 1'b0;
  endtask

  // one lrck period; model predicts, observations recorded
  task automatic run_frame(
    input bit wr_en, input logic [31:0] wdat,
    input bit scr
  );
    int m, v, pres;
    logic [31:0] head;
    m    = int'(bus.mode);
    v    = int'(bus.fifo_vol);
    pres = q_m.size();
    head = 32'h8000_8000;
    if (m == 1 || m == 2) begin
      if (pres == 0) und_m = 1'b1;
      else head = q_m[0];
    end
    if (wr_en && pres >= DEPTH) ovf_m = 1'b1;
    if ((m == 1 || m == 2) && pres > 0)
      void'(q_m.pop_front());
    if (wr_en && pres < DEPTH) q_m.push_back(wdat);
    p_l = e_l;
    p_r = e_r;
    e_l = ref_ch(m, v, bus.live_left, head[31:16]);
    e_r = ref_ch(m, v, bus.live_right, head[15:0]);
    bus.lrck = 1'b1;
    o_first = -1;
    o_hi = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 3 && wr_en) begin
        bus.fifo_wr  = 1'b1;
        bus.fifo_din = wdat;
      end
      if (t == 4) begin
        bus.fifo_wr = 1'b0;
        if (scr) begin
          bus.mode     = 2'($urandom);
          bus.fifo_vol = 2'($urandom);
        end
      end
      if (t == 5) begin
        o_l5 = bus.left;
        o_r5 = bus.right;
        if (scr) begin
          bus.live_left  = 16'($urandom);
          bus.live_right = 16'($urandom);
        end
      end
      if (t == 6) begin
        o_l6 = bus.left;
        o_r6 = bus.right;
      end
      if (bus.frame_tick === 1'b1) begin
        if (o_first < 0) o_first = t;
        o_hi++;
      end
    end
    bus.lrck = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    q_m.delete();
    und_m = 0; ovf_m = 0;
    e_l = 16'h8000; e_r = 16'h8000;
    vecs++; if (bus.left !== 16'h8000) begin errs++; $display("FAIL reset_left got %h want 8000", bus.left); end
    vecs++; if (bus.right !== 16'h8000) begin errs++; $display("FAIL reset_right got %h want 8000", bus.right); end
    vecs++; if (bus.frame_tick !== 1'b0) begin errs++; $display("FAIL reset_tick got %b want 0", bus.frame_tick); end
    vecs++; if (bus.fifo_level !== 5'd0) begin errs++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    vecs++; if (bus.fifo_full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
    vecs++; if (bus.underrun !== 1'b0 || bus.overflow !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b want 00", bus.underrun, bus.overflow); end
  endtask

  task automatic test_live();
    bus.mode = 2'd0;
    bus.live_left = 16'h1234;
    bus.live_right = 16'hF000;
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0, 0);
      vecs++; if (o_first !== 6) begin errs++; $display("FAIL live_latency got %0d want 6", o_first); end
      vecs++; if (o_hi !== 1) begin errs++; $display("FAIL live_tick_width got %0d want 1", o_hi); end
      vecs++; if (o_l5 !== p_l) begin errs++; $display("FAIL live_early got %h want %h", o_l5, p_l); end
      vecs++; if (o_l6 !== 16'h1234) begin errs++; $display("FAIL live_left got %h want 1234", o_l6); end
      vecs++; if (o_r6 !== 16'hF000) begin errs++; $display("FAIL live_right got %h want f000", o_r6); end
      vecs++; if (bus.underrun !== 1'b0) begin errs++; $display("FAIL live_underrun got %b want 0", bus.underrun); end
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] w [3];
    w[0] = {16'hA000, 16'h6000};
    w[1] = {16'h7123, 16'h0042};
    w[2] = {16'hFFFF, 16'h8001};
    bus.mode = 2'd1;
    bus.fifo_vol = 2'd0;
    for (int i = 0; i < 3; i++) push(w[i]);
    vecs++; if (bus.fifo_level !== 5'd3) begin errs++; $display("FAIL order_level got %0d want 3", bus.fifo_level); end
    for (int f = 0; f < 4; f++) begin
      run_frame(0, 0, 0);
      vecs++; if ({o_l6, o_r6} !== (f < 3 ? w[f] : 32'h8000_8000)) begin errs++; $display("FAIL order_word%0d got %h%h", f, o_l6, o_r6); end
      vecs++; if (bus.fifo_level !== 5'(2 - (f < 3 ? f : 2))) begin errs++; $display("FAIL order_level%0d got %0d", f, bus.fifo_level); end
      vecs++; if (bus.underrun !== und_m) begin errs++; $display("FAIL order_underrun%0d got %b want %b", f, bus.underrun, und_m); end
    end
    clr_flags();
    vecs++; if (bus.underrun !== 1'b0) begin errs++; $display("FAIL order_clr got %b want 0", bus.underrun); end
    run_frame(1, 32'h5A5A_C3C3, 0);
    vecs++; if (bus.underrun !== 1'b1) begin errs++; $display("FAIL empty_fetch_underrun got %b want 1", bus.underrun); end
    vecs++; if (bus.fifo_level !== 5'd1) begin errs++; $display("FAIL empty_fetch_level got %0d want 1", bus.fifo_level); end
    run_frame(0, 0, 0);
    vecs++; if ({o_l6, o_r6} !== 32'h5A5A_C3C3) begin errs++; $display("FAIL empty_fetch_word got %h%h want 5a5ac3c3", o_l6, o_r6); end
    clr_flags();
  endtask

  task automatic test_saturation();
    logic [15:0] lv [3];
    logic [15:0] fv [3];
    logic [15:0] ex [3];
    lv[0] = 16'hF000; fv[0] = 16'hF000; ex[0] = 16'hFFFF;
    lv[1] = 16'h1000; fv[1] = 16'h1000; ex[1] = 16'h0000;
    lv[2] = 16'h9000; fv[2] = 16'h7000; ex[2] = 16'h8000;
    bus.mode = 2'd2;
    bus.fifo_vol = 2'd0;
    for (int i = 0; i < 3; i++) begin
      bus.live_left  = lv[i];
      bus.live_right = lv[i];
      push({fv[i], fv[i]});
      run_frame(0, 0, 0);
      vecs++; if (o_l6 !== ex[i] || o_r6 !== ex[i]) begin errs++; $display("FAIL sat%0d got %h/%h want %h", i, o_l6, o_r6, ex[i]); end
    end
  endtask

  task automatic test_vol();
    bus.mode = 2'd1;
    bus.fifo_vol = 2'd2;
    push({16'hC000, 16'h0000});
    run_frame(0, 0, 0);
    vecs++; if (o_l6 !== 16'h9000) begin errs++; $display("FAIL vol_pos got %h want 9000", o_l6); end
    vecs++; if (o_r6 !== 16'h6000) begin errs++; $display("FAIL vol_neg got %h want 6000", o_r6); end
    bus.fifo_vol = 2'd3;
    push({16'h0000, 16'hFFFF});
    run_frame(0, 0, 0);
    vecs++; if (o_l6 !== e_l || o_r6 !== e_r) begin errs++; $display("FAIL vol3 got %h%h want %h%h", o_l6, o_r6, e_l, e_r); end
  endtask

  task automatic test_overflow();
    bus.mode = 2'd0;
    for (int i = 0; i < DEPTH; i++)
      push({16'(i * 16'h0111), 16'(16'hF000 - i)});
    vecs++; if (bus.fifo_full !== 1'b1) begin errs++; $display("FAIL ovf_full got %b want 1", bus.fifo_full); end
    vecs++; if (bus.fifo_level !== 5'd16) begin errs++; $display("FAIL ovf_level got %0d want 16", bus.fifo_level); end
    vecs++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
    bus.fifo_wr = 1'b1;
    bus.fifo_din = 32'h1111_2222;
    bus.flags_clr = 1'b1;
    tick();
    bus.fifo_wr = 1'b0;
    bus.flags_clr = 1'b0;
    vecs++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr_prio got %b want 0", bus.overflow); end
    push(32'hBAD0_BAD0);
    vecs++; if (bus.overflow !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    vecs++; if (bus.fifo_level !== 5'd16) begin errs++; $display("FAIL ovf_level2 got %0d want 16", bus.fifo_level); end
    bus.mode = 2'd1;
    bus.fifo_vol = 2'd0;
    run_frame(1, 32'hDEAD_BEEF, 0);
    vecs++; if (bus.fifo_level !== 5'd15) begin errs++; $display("FAIL ovf_fetch_level got %0d want 15", bus.fifo_level); end
    vecs++; if (o_l6 !== e_l || o_r6 !== e_r) begin errs++; $display("FAIL ovf_first got %h%h want %h%h", o_l6, o_r6, e_l, e_r); end
    for (int f = 0; f < 16; f++) begin
      run_frame(0, 0, 0);
      vecs++; if (o_l6 !== e_l || o_r6 !== e_r) begin errs++; $display("FAIL drain%0d got %h%h want %h%h", f, o_l6, o_r6, e_l, e_r); end
    end
    vecs++; if (bus.underrun !== 1'b1 || o_l6 !== 16'h8000) begin errs++; $display("FAIL drain_end got %b/%h want 1/8000", bus.underrun, o_l6); end
    clr_flags();
  endtask

  task automatic test_reset_midframe();
    int hi;
    push(32'h1357_9BDF);
    push(32'h2468_ACE0);
    bus.mode = 2'd1;
    bus.lrck = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    bus.lrck = 1'b0;
    tick();
    vecs++; if (bus.left !== 16'h8000 || bus.right !== 16'h8000) begin errs++; $display("FAIL midrst_out got %h%h want 80008000", bus.left, bus.right); end
    vecs++; if (bus.fifo_level !== 5'd0) begin errs++; $display("FAIL midrst_level got %0d want 0", bus.fifo_level); end
    hi = 0;
    for (int t = 0; t < 6; t++) begin
      if (bus.frame_tick !== 1'b0) hi++;
      tick();
    end
    vecs++; if (hi !== 0) begin errs++; $display("FAIL midrst_tick got %0d want 0", hi); end
    reset = 1'b0;
    q_m.delete();
    und_m = 0; ovf_m = 0;
    e_l = 16'h8000; e_r = 16'h8000;
    repeat (4) tick();
    bus.mode = 2'd0;
    bus.live_left = 16'h5555;
    bus.live_right = 16'hAAAA;
    run_frame(0, 0, 0);
    vecs++; if (o_first !== 6 || o_l6 !== 16'h5555 || o_r6 !== 16'hAAAA) begin errs++; $display("FAIL midrst_resume got %0d %h%h", o_first, o_l6, o_r6); end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 14) : $urandom_range(0, 2);
      bus.mode = 2'd0;
      repeat (n) push($urandom);
      if ($urandom_range(0, 5) == 0) clr_flags();
      bus.mode = 2'($urandom);
      bus.fifo_vol = 2'($urandom);
      bus.live_left = 16'($urandom);
      bus.live_right = 16'($urandom);
      run_frame($urandom_range(0, 3) == 0, $urandom, 1);
      vecs++; if (o_first !== 6 || o_hi !== 1) begin errs++; $display("FAIL rnd%0d_tick got %0d/%0d want 6/1", i, o_first, o_hi); end
      vecs++; if (o_l5 !== p_l || o_r5 !== p_r) begin errs++; $display("FAIL rnd%0d_early got %h%h want %h%h", i, o_l5, o_r5, p_l, p_r); end
      vecs++; if (o_l6 !== e_l || o_r6 !== e_r) begin errs++; $display("FAIL rnd%0d_out got %h%h want %h%h", i, o_l6, o_r6, e_l, e_r); end
      vecs++; if (bus.underrun !== und_m || bus.overflow !== ovf_m) begin errs++; $display("FAIL rnd%0d_flags got %b%b want %b%b", i, bus.underrun, bus.overflow, und_m, ovf_m); end
      vecs++; if (int'(bus.fifo_level) !== q_m.size() || bus.fifo_full !== (q_m.size() == DEPTH)) begin errs++; $display("FAIL rnd%0d_level got %0d want %0d", i, bus.fifo_level, q_m.size()); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.lrck = 1'b0;
    bus.mode = 2'd0;
    bus.fifo_vol = 2'd0;
    bus.live_left = 16'h8000;
    bus.live_right = 16'h8000;
    bus.fifo_wr = 1'b0;
    bus.fifo_din = '0;
    bus.flags_clr = 1'b0;
    test_reset();
    test_live();
    test_fifo_order();
    test_saturation();
    test_vol();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
